// File: rtl/n_bit_down_counter.sv
// Loadable N-bit down counter with one-shot and periodic modes.
// Synchronous active-low reset; done pulses on the terminal count.
module n_bit_down_counter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   input  logic         auto_reload,
   output logic [N-1:0] count_out,
   output logic         done,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [N-1:0] ZERO = '0;
   localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

   state_t       state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] rel_q, rel_d;
   logic         done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      done_d  = 1'b0;
      if (load) begin
         cnt_d   = load_val;
         rel_d   = load_val;
         state_d = (load_val != ZERO) ? RUN : IDLE;
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN, PAUSE: begin
               if (!en) begin
                  state_d = PAUSE;
               end else begin
                  state_d = RUN;
                  unique case (1'b1)
                     (cnt_q > ONE): cnt_d = cnt_q - ONE;
                     (cnt_q == ONE): begin
                        cnt_d  = ZERO;
                        done_d = 1'b1;
                        if (!auto_reload) state_d = IDLE;
                     end
                     default: begin
                        // zero count: reload in periodic mode, else stop at 0
                        if (auto_reload) cnt_d = rel_q;
                        else state_d = IDLE;
                     end
                  endcase
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= ZERO;
         rel_q   <= ZERO;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         done_q  <= done_d;
      end
   end

   assign count_out = cnt_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);

endmodule
